// File: rtl/day07_result_printer_if.sv
// rtl/day07_result_printer_if.sv - byte stream from the result printer to the UART TX FIFO
//
// tx_data   8-bit ASCII byte offered downstream
// tx_valid  tx_data is valid
// tx_ready  downstream accepts; transfer when tx_valid and tx_ready are both high
interface day07_result_printer_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/day07_result_printer.sv
// rtl/day07_result_printer.sv - prints two unsigned results as decimal ASCII lines
//
// Ports:
//   clk           sole clock, rising edge
//   rst           asynchronous active-high reset
//   part1_result  part-1 answer (DATA_W bits)
//   part2_result  part-2 answer (DATA_W bits)
//   done          results valid while high; sampled once in IDLE
//   tx            byte stream master (tx_data/tx_valid/tx_ready)
//   finished      all bytes transferred; sticky until reset
//
// Each operand is converted by repeated restoring division by 10 (one
// quotient bit per cycle). Digits come out LSB first, so they are buffered
// and then replayed from the highest index down.
module day07_result_printer #(
  parameter int         DATA_W     = 64,
  parameter int         MAX_DIGITS = 20,
  parameter logic [7:0] TERM_CHAR  = 8'h0A
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_W-1:0]          part1_result,
  input  logic [DATA_W-1:0]          part2_result,
  input  logic                       done,
  output logic                       finished,
  day07_result_printer_if.master     tx
);

  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam int BW = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_DIV, S_STORE, S_EMIT, S_TERM, S_FINISH
  } state_t;

  state_t            state, state_n;
  logic              tx_valid_q, tx_valid_n;
  logic [7:0]        tx_data_q, tx_data_n;

  // part1 is latched straight into the dividend; only part2 needs a holding register
  logic [DATA_W-1:0] op2;
  logic [DATA_W-1:0] dvd;
  logic [3:0]        rem;
  logic [BW-1:0]     bit_cnt;
  logic [CW-1:0]     count;
  logic [CW-1:0]     emit_idx;
  logic              sel;
  logic [7:0]        digit_buf [MAX_DIGITS];

  logic [4:0]        shifted;
  logic              q_bit;
  logic [3:0]        rem_n;
  logic [7:0]        digit_ch;
  logic              xfer;
  logic              div_last;

  assign tx.tx_data  = tx_data_q;
  assign tx.tx_valid = tx_valid_q;

  // Restoring step: bring in the next dividend bit, subtract 10 if it fits.
  // Remainder stays <= 9, so 4 bits always suffice after the subtract.
  always_comb begin
    shifted  = {rem, dvd[DATA_W-1]};
    q_bit    = (shifted >= 5'd10);
    rem_n    = q_bit ? 4'(shifted - 5'd10) : shifted[3:0];
    digit_ch = {4'h0, rem} + 8'h30;
    xfer     = tx_valid_q & tx.tx_ready;
    div_last = (bit_cnt == BW'(DATA_W - 1));
  end

  always_comb begin
    state_n    = state;
    tx_valid_n = tx_valid_q;
    tx_data_n  = tx_data_q;
    case (state)
      S_IDLE: if (done) state_n = S_DIV;
      S_DIV:  if (div_last) state_n = S_STORE;
      S_STORE: begin
        if (dvd != '0) begin
          state_n = S_DIV;
        end else begin
          // The digit being written is the most significant one: offer it directly
          state_n    = S_EMIT;
          tx_valid_n = 1'b1;
          tx_data_n  = digit_ch;
        end
      end
      S_EMIT: begin
        if (xfer) begin
          if (emit_idx == '0) begin
            state_n   = S_TERM;
            tx_data_n = TERM_CHAR;
          end else begin
            tx_data_n = digit_buf[emit_idx - CW'(1)];
          end
        end
      end
      S_TERM: begin
        if (xfer) begin
          tx_valid_n = 1'b0;
          tx_data_n  = 8'h00;
          state_n    = sel ? S_FINISH : S_DIV;
        end
      end
      S_FINISH: state_n = S_FINISH;
      default:  state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      state      <= state_n;
      tx_valid_q <= tx_valid_n;
      tx_data_q  <= tx_data_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op2      <= '0;
      dvd      <= '0;
      rem      <= '0;
      bit_cnt  <= '0;
      count    <= '0;
      emit_idx <= '0;
      sel      <= 1'b0;
      finished <= 1'b0;
    end else begin
      finished <= (state_n == S_FINISH);
      case (state)
        S_IDLE: begin
          if (done) begin
            op2     <= part2_result;
            dvd     <= part1_result;
            rem     <= '0;
            bit_cnt <= '0;
            count   <= '0;
            sel     <= 1'b0;
          end
        end
        S_DIV: begin
          dvd     <= {dvd[DATA_W-2:0], q_bit};
          rem     <= rem_n;
          bit_cnt <= div_last ? '0 : bit_cnt + BW'(1);
        end
        S_STORE: begin
          count <= count + CW'(1);
          if (dvd != '0) rem <= '0;
          else           emit_idx <= count;
        end
        S_EMIT: begin
          if (xfer && emit_idx != '0) emit_idx <= emit_idx - CW'(1);
        end
        S_TERM: begin
          if (xfer && !sel) begin
            dvd   <= op2;
            rem   <= '0;
            count <= '0;
            sel   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Digit storage needs no reset: every entry is written before it is read
  always_ff @(posedge clk) begin
    if (state == S_STORE) digit_buf[count] <= digit_ch;
  end

endmodule

// File: tb/tb_day07_result_printer.sv
// tb/tb_day07_result_printer.sv - directed self-checking bench for day07_result_printer
module tb_day07_result_printer;
  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] part1_result;
  logic [63:0] part2_result;
  logic        done;
  logic        finished;
  int          checks = 0;
  int          errors = 0;

  day07_result_printer_if tx_if ();

  day07_result_printer dut (
    .clk          (clk),
    .rst          (rst),
    .part1_result (part1_result),
    .part2_result (part2_result),
    .done         (done),
    .finished     (finished),
    .tx           (tx_if.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run(input logic [63:0] p1, input logic [63:0] p2, input string exp,
                     input int first_edge, input bit toggle, input bit drop_done,
                     input int stop_after);
    int         edges = 0;
    int         n = 0;
    bit         seen = 0;
    bit         stall_bad = 0;
    bit         fin_bad = 0;
    bit         hold = 0;
    logic [7:0] held = 8'h00;
    logic [7:0] got [64];
    part1_result = p1;
    part2_result = p2;
    done = 1'b1;
    while (edges < 20000) begin
      @(negedge clk);
      edges++;
      if (edges == 1) begin
        part1_result = ~p1;
        part2_result = ~p2;
        if (drop_done) done = 1'b0;
      end
      if (hold && !(tx_if.tx_valid === 1'b1 && tx_if.tx_data === held)) stall_bad = 1;
      if (finished !== (n == exp.len())) fin_bad = 1;
      if (tx_if.tx_valid === 1'b1 && !seen) begin
        seen = 1;
        if (first_edge > 0) check("first_valid_edge", edges, first_edge);
      end
      tx_if.tx_ready = toggle ? edges[0] : 1'b1;
      hold = (tx_if.tx_valid === 1'b1) && !tx_if.tx_ready;
      held = tx_if.tx_data;
      if (tx_if.tx_valid === 1'b1 && tx_if.tx_ready) begin
        if (n < 64) got[n] = tx_if.tx_data;
        n++;
      end
      if (stop_after > 0 && n == stop_after) return;
      if (finished === 1'b1 && n == exp.len()) break;
    end
    check("saw_valid", seen, 1'b1);
    check("byte_count", n, exp.len());
    for (int i = 0; i < exp.len() && i < n && i < 64; i++) begin
      logic [7:0] e;
      e = exp[i];
      check("byte", got[i], e);
    end
    check("stall_stable", stall_bad, 1'b0);
    check("finished_timing", fin_bad, 1'b0);
  endtask

  task automatic do_reset();
    done = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_tx_valid", tx_if.tx_valid, 1'b0);
    check("rst_tx_data", tx_if.tx_data, 8'h00);
    check("rst_finished", finished, 1'b0);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    bit bad;
    rst = 1'b1;
    done = 1'b0;
    part1_result = '0;
    part2_result = '0;
    tx_if.tx_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_tx_valid", tx_if.tx_valid, 1'b0);
    check("reset_tx_data", tx_if.tx_data, 8'h00);
    check("reset_finished", finished, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    run(64'd21, 64'd40, "21\n40\n", 131, 1'b0, 1'b0, 0);

    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      tx_if.tx_ready = i[0];
      if (tx_if.tx_valid !== 1'b0 || finished !== 1'b1) bad = 1;
    end
    check("post_finish_quiet", bad, 1'b0);

    do_reset();
    run(64'd0, 64'd0, "0\n0\n", 66, 1'b0, 1'b1, 0);

    do_reset();
    run(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
        "18446744073709551615\n18446744073709551615\n", 1301, 1'b0, 1'b0, 0);

    do_reset();
    run(64'd1583, 64'd7, "1583\n7\n", 261, 1'b1, 1'b1, 0);

    do_reset();
    run(64'd1583, 64'd7, "1583\n7\n", 261, 1'b0, 1'b0, 2);
    @(posedge clk);
    #1;
    check("pre_abort_valid", tx_if.tx_valid, 1'b1);
    rst = 1'b1;
    #1;
    check("abort_tx_valid", tx_if.tx_valid, 1'b0);
    check("abort_finished", finished, 1'b0);
    done = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tx_if.tx_valid !== 1'b0) bad = 1;
    end
    check("abort_quiet", bad, 1'b0);
    run(64'd1583, 64'd7, "1583\n7\n", 261, 1'b0, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
